// File: rtl/accel_sequencer.sv
// Accelerometer sequencer: writes the three init registers, then on every sample tick
// reads X/Y over a request/ack byte engine and publishes a coherent 16-bit sample pair.
module accel_sequencer #(
   parameter int unsigned TICK_DIV = 25000000,
   parameter int unsigned TIMEOUT  = 4096,
   parameter logic [7:0]  FMT_VAL  = 8'h40,
   parameter logic [7:0]  RATE_VAL = 8'h0A
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   output logic        spi_req,
   output logic        spi_wr,
   output logic [5:0]  spi_addr,
   output logic [7:0]  spi_wdata,
   input  logic        spi_ack,
   input  logic [7:0]  spi_rdata,
   output logic [15:0] data_x,
   output logic [15:0] data_y,
   output logic        data_update,
   output logic        init_done,
   output logic        overrun,
   output logic        err_timeout
);

   localparam int unsigned       TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned       TO_W      = $clog2(TIMEOUT + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_READ, ST_COMMIT} state_t;

   state_t            state_q;
   logic [1:0]        idx_q;
   logic              spi_req_q, spi_wr_q;
   logic [5:0]        spi_addr_q;
   logic [7:0]        spi_wdata_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic              err_timeout_q, init_done_q, data_update_q;
   logic [15:0]       data_x_q, data_y_q;
   logic [7:0]        shadow_q [4];
   logic              tick_wrap, start_read, ack_valid, to_expired;

   function automatic logic [5:0] init_addr(input logic [1:0] idx);
      case (idx)
         2'd0:    return 6'h31;
         2'd1:    return 6'h2C;
         default: return 6'h2D;
      endcase
   endfunction

   function automatic logic [7:0] init_data(input logic [1:0] idx);
      case (idx)
         2'd0:    return FMT_VAL;
         2'd1:    return RATE_VAL;
         default: return 8'h08;
      endcase
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      pending_d  = pending_q;
      overrun_d  = overrun_q;
      tick_wrap  = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
      start_read = (state_q == ST_IDLE) && pending_q && !hold;
      ack_valid  = spi_ack && spi_req_q;
      to_expired = spi_req_q && !spi_ack && (to_cnt_q == TO_LAST);
      // A wrap coinciding with the pending clear re-arms pending without counting an overrun.
      if (tick_wrap) begin
         pending_d = 1'b1;
         if (pending_q && !start_read) overrun_d = 1'b1;
      end else if (start_read) begin
         pending_d = 1'b0;
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_INIT;
         idx_q         <= '0;
         spi_req_q     <= 1'b0;
         spi_wr_q      <= 1'b0;
         spi_addr_q    <= '0;
         spi_wdata_q   <= '0;
         to_cnt_q      <= '0;
         tick_cnt_q    <= '0;
         pending_q     <= 1'b0;
         overrun_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         init_done_q   <= 1'b0;
         data_update_q <= 1'b0;
         data_x_q      <= '0;
         data_y_q      <= '0;
         // NOTE: the shadow bytes are small flops, not RAM, so clearing them on reset is cheap and required.
         for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         pending_q     <= pending_d;
         overrun_q     <= overrun_d;
         data_update_q <= 1'b0;
         if (spi_req_q) to_cnt_q <= to_cnt_q + 1'b1;

         if (to_expired) begin
            spi_req_q     <= 1'b0;
            err_timeout_q <= 1'b1;
            init_done_q   <= 1'b0;
            idx_q         <= '0;
            state_q       <= ST_INIT;
         end else begin
            case (state_q)
               ST_INIT: begin
                  if (!spi_req_q) begin
                     spi_req_q   <= 1'b1;
                     spi_wr_q    <= 1'b1;
                     spi_addr_q  <= init_addr(idx_q);
                     spi_wdata_q <= init_data(idx_q);
                     to_cnt_q    <= '0;
                  end else if (ack_valid) begin
                     spi_req_q <= 1'b0;
                     if (idx_q == 2'd2) begin
                        idx_q       <= '0;
                        init_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                     end else begin
                        idx_q <= idx_q + 2'd1;
                     end
                  end
               end
               ST_IDLE: begin
                  if (start_read) begin
                     spi_req_q   <= 1'b1;
                     spi_wr_q    <= 1'b0;
                     spi_addr_q  <= 6'h32;
                     spi_wdata_q <= '0;
                     to_cnt_q    <= '0;
                     idx_q       <= '0;
                     state_q     <= ST_READ;
                  end
               end
               ST_READ: begin
                  if (!spi_req_q) begin
                     spi_req_q   <= 1'b1;
                     spi_wr_q    <= 1'b0;
                     spi_addr_q  <= 6'h32 + {4'd0, idx_q};
                     spi_wdata_q <= '0;
                     to_cnt_q    <= '0;
                  end else if (ack_valid) begin
                     shadow_q[idx_q] <= spi_rdata;
                     spi_req_q       <= 1'b0;
                     if (idx_q == 2'd3) begin
                        // Publish both axes together, visible during the COMMIT cycle.
                        data_x_q      <= {shadow_q[1], shadow_q[0]};
                        data_y_q      <= {spi_rdata, shadow_q[2]};
                        data_update_q <= 1'b1;
                        idx_q         <= '0;
                        state_q       <= ST_COMMIT;
                     end else begin
                        idx_q <= idx_q + 2'd1;
                     end
                  end
               end
               ST_COMMIT: state_q <= ST_IDLE;
               default:   state_q <= ST_INIT;
            endcase
         end
      end
   end

   assign spi_req     = spi_req_q;
   assign spi_wr      = spi_wr_q;
   assign spi_addr    = spi_addr_q;
   assign spi_wdata   = spi_wdata_q;
   assign data_x      = data_x_q;
   assign data_y      = data_y_q;
   assign data_update = data_update_q;
   assign init_done   = init_done_q;
   assign overrun     = overrun_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_accel_sequencer.sv
// Bench for accel_sequencer: a 3-cycle-ack SPI engine model, a table of sample vectors,
// and directed sequences for hold/overrun, ack timeout, mid-read reset and stray acks.
module tb_accel_sequencer;

   localparam int TICK_DIV = 16;
   localparam int TIMEOUT  = 8;
   localparam int BOUND    = 80;

   logic        clk = 1'b0;
   logic        reset, hold;
   logic        spi_req, spi_wr, spi_ack;
   logic [5:0]  spi_addr;
   logic [7:0]  spi_wdata, spi_rdata;
   logic [15:0] data_x, data_y;
   logic        data_update, init_done, overrun, err_timeout;

   logic        eng_ack = 1'b0, stray_ack = 1'b0;
   logic [7:0]  eng_rdata = 8'h00, stray_rdata = 8'h00;
   assign spi_ack   = eng_ack | stray_ack;
   assign spi_rdata = stray_ack ? stray_rdata : eng_rdata;

   typedef struct packed {
      logic       wr;
      logic [5:0] addr;
      logic [7:0] wdata;
   } txn_t;

   typedef struct {
      logic [7:0]  x0, x1, y0, y1;
      logic [15:0] exp_x, exp_y;
   } vec_t;

   txn_t        log_q[$];
   txn_t        cur;
   logic [7:0]  rd_mem [4];
   bit          withhold = 1'b0;
   int          age = 0, hs_err = 0, chg_err = 0, upd_cnt = 0, cyc = 0, ack35_cyc = 0;
   int          n_cmp = 0, n_err = 0;
   logic [15:0] prev_x = '0, prev_y = '0;
   bit          prev_rst = 1'b1;

   accel_sequencer #(
      .TICK_DIV (TICK_DIV),
      .TIMEOUT  (TIMEOUT),
      .FMT_VAL  (8'h40),
      .RATE_VAL (8'h0A)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hold        (hold),
      .spi_req     (spi_req),
      .spi_wr      (spi_wr),
      .spi_addr    (spi_addr),
      .spi_wdata   (spi_wdata),
      .spi_ack     (spi_ack),
      .spi_rdata   (spi_rdata),
      .data_x      (data_x),
      .data_y      (data_y),
      .data_update (data_update),
      .init_done   (init_done),
      .overrun     (overrun),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic txn_t mk(input logic wr, input logic [5:0] a, input logic [7:0] d);
      return '{wr: wr, addr: a, wdata: d};
   endfunction

   // Engine model: logs each request, checks stability and the post-ack low cycle, acks after 3 cycles.
   initial forever begin
      @(posedge clk);
      #1;
      if (eng_ack && spi_req) hs_err++;
      eng_ack = 1'b0;
      if (spi_req) begin
         if (age == 0) begin
            cur = mk(spi_wr, spi_addr, spi_wdata);
            log_q.push_back(cur);
         end else if (mk(spi_wr, spi_addr, spi_wdata) != cur) begin
            hs_err++;
         end
         age++;
         if (age == 3 && !(withhold && !spi_wr && spi_addr == 6'h33)) begin
            eng_ack   = 1'b1;
            eng_rdata = (spi_addr >= 6'h32 && spi_addr <= 6'h35) ? rd_mem[spi_addr[1:0] - 2'd2] : 8'h00;
            if (spi_addr == 6'h35) ack35_cyc = cyc;
         end
      end else begin
         age = 0;
      end
   end

   // Output monitor: data may only move together with data_update (reset excepted).
   initial forever begin
      @(negedge clk);
      if (data_update === 1'b1) upd_cnt++;
      if (!prev_rst && (data_x !== prev_x || data_y !== prev_y) && data_update !== 1'b1) chg_err++;
      prev_x   = data_x;
      prev_y   = data_y;
      prev_rst = reset;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_req(input logic [5:0] a, output bit ok);
      int n = 0;
      while (!(spi_req === 1'b1 && spi_addr == a) && n < BOUND) begin
         step();
         n++;
      end
      ok = (spi_req === 1'b1 && spi_addr == a);
   endtask

   task automatic wait_init(output bit ok);
      int n = 0;
      while (init_done !== 1'b1 && n < BOUND) begin
         step();
         n++;
      end
      ok = (init_done === 1'b1);
   endtask

   // Release hold until a burst starts, re-freeze, then wait for the resulting commit.
   task automatic read_burst(output bit ok);
      int n = 0;
      bit started;
      hold = 1'b0;
      wait_req(6'h32, started);
      hold = 1'b1;
      while (data_update !== 1'b1 && n < BOUND) begin
         step();
         n++;
      end
      ok = started && (data_update === 1'b1);
   endtask

   initial begin
      vec_t vecs[5];
      txn_t exp_init[3];
      bit   ok;
      int   base, u0, hi, upd_cyc;

      vecs[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 16'h1234, 16'hABCD};
      vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF};
      vecs[3] = '{8'h01, 8'h80, 8'h7F, 8'h00, 16'h8001, 16'h007F};
      vecs[4] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 16'h5AA5, 16'hC33C};
      exp_init[0] = mk(1'b1, 6'h31, 8'h40);
      exp_init[1] = mk(1'b1, 6'h2C, 8'h0A);
      exp_init[2] = mk(1'b1, 6'h2D, 8'h08);

      reset = 1'b1;
      hold  = 1'b1;
      for (int i = 0; i < 4; i++) rd_mem[i] = 8'h00;
      repeat (3) step();
      check("rst_spi_req", 32'(spi_req), 32'd0);
      check("rst_data_x", 32'(data_x), 32'd0);
      check("rst_data_y", 32'(data_y), 32'd0);
      check("rst_update", 32'(data_update), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_err_timeout", 32'(err_timeout), 32'd0);

      reset = 1'b0;
      step();
      check("init_first_req", 32'(spi_req), 32'd1);
      check("init_first_addr", 32'(spi_addr), 32'h31);
      wait_init(ok);
      check("init_done_set", 32'(ok), 32'd1);
      check("init_txn_count", 32'(log_q.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < log_q.size()) check($sformatf("init_txn%0d", i), 32'(log_q[i]), 32'(exp_init[i]));
      check("overrun_clear_after_init", 32'(overrun), 32'd0);

      stray_rdata = 8'hEE;
      stray_ack   = 1'b1;
      step();
      stray_ack = 1'b0;
      repeat (3) step();
      check("stray_no_req", 32'(spi_req), 32'd0);
      check("stray_no_update", 32'(upd_cnt), 32'd0);
      check("stray_no_txn", 32'(log_q.size()), 32'd3);
      check("stray_data_x", 32'(data_x), 32'd0);

      repeat (40) step();
      check("hold_no_reads", 32'(log_q.size()), 32'd3);
      check("hold_overrun", 32'(overrun), 32'd1);

      for (int i = 0; i < 5; i++) begin
         rd_mem[0] = vecs[i].x0;
         rd_mem[1] = vecs[i].x1;
         rd_mem[2] = vecs[i].y0;
         rd_mem[3] = vecs[i].y1;
         base = log_q.size();
         u0   = upd_cnt;
         read_burst(ok);
         upd_cyc = cyc;
         check($sformatf("vec%0d_update", i), 32'(ok), 32'd1);
         check($sformatf("vec%0d_data_x", i), 32'(data_x), 32'(vecs[i].exp_x));
         check($sformatf("vec%0d_data_y", i), 32'(data_y), 32'(vecs[i].exp_y));
         if (i == 0) begin
            check("commit_latency", 32'(upd_cyc - ack35_cyc), 32'd1);
            repeat (40) step();
            check("one_burst_updates", 32'(upd_cnt - u0), 32'd1);
            check("one_burst_txns", 32'(log_q.size() - base), 32'd4);
            for (int k = 0; k < 4; k++)
               if (base + k < log_q.size())
                  check($sformatf("burst_txn%0d", k), 32'(log_q[base + k]),
                        32'(mk(1'b0, 6'h32 + 6'(k), 8'h00)));
         end
      end

      withhold = 1'b1;
      hold     = 1'b0;
      wait_req(6'h32, ok);
      hold = 1'b1;
      wait_req(6'h33, ok);
      check("to_second_read_seen", 32'(ok), 32'd1);
      hi = 0;
      while (spi_req === 1'b1 && hi < 30) begin
         hi++;
         step();
      end
      check("to_req_width", 32'(hi), 32'd8);
      check("to_err_timeout", 32'(err_timeout), 32'd1);
      check("to_init_done", 32'(init_done), 32'd0);
      check("to_keep_x", 32'(data_x), 32'h5AA5);
      check("to_keep_y", 32'(data_y), 32'hC33C);
      base = log_q.size();
      hi   = 0;
      while (log_q.size() == base && hi < 10) begin
         step();
         hi++;
      end
      check("to_restart_seen", 32'(log_q.size() > base), 32'd1);
      if (log_q.size() > base) check("to_restart_txn", 32'(log_q[base]), 32'(exp_init[0]));
      withhold = 1'b0;
      wait_init(ok);
      check("to_reinit_done", 32'(ok), 32'd1);

      hold = 1'b0;
      wait_req(6'h32, ok);
      hold = 1'b1;
      wait_req(6'h34, ok);
      check("rr_third_read_seen", 32'(ok), 32'd1);
      u0    = upd_cnt;
      base  = log_q.size();
      reset = 1'b1;
      step();
      check("rr_spi_req", 32'(spi_req), 32'd0);
      check("rr_data_x", 32'(data_x), 32'd0);
      check("rr_data_y", 32'(data_y), 32'd0);
      check("rr_flags", 32'({data_update, init_done, overrun, err_timeout}), 32'd0);
      reset       = 1'b0;
      stray_rdata = 8'h77;
      stray_ack   = 1'b1;
      step();
      stray_ack = 1'b0;
      check("rr_init_restart_req", 32'(spi_req), 32'd1);
      check("rr_init_restart_addr", 32'(spi_addr), 32'h31);
      wait_init(ok);
      check("rr_reinit_done", 32'(ok), 32'd1);
      check("rr_first_txn", 32'(log_q[base]), 32'(exp_init[0]));
      check("rr_no_update", 32'(upd_cnt - u0), 32'd0);
      check("rr_data_after", 32'({data_x, data_y}), 32'd0);
      check("rr_err_timeout", 32'(err_timeout), 32'd0);

      check("handshake_errors", 32'(hs_err), 32'd0);
      check("data_change_errors", 32'(chg_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/accel_sequencer.md
ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000000: clk cycles per sample period (1 Hz at 25 MHz).
REQ-002 Parameter TIMEOUT, default 4096: max clk cycles between spi_req rise and spi_ack.
REQ-003 Parameter FMT_VAL, default 8'h40: DATA_FORMAT (addr 6'h31) init value.
REQ-004 Parameter RATE_VAL, default 8'h0A: BW_RATE (addr 6'h2C) init value.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 hold  input  1  freeze: no new sample read starts while high.
REQ-008 spi_req  output  1  transaction request to SPI byte engine.
REQ-009 spi_wr  output  1  1 = register write, 0 = register read.
REQ-010 spi_addr  output  6  accelerometer register address.
REQ-011 spi_wdata  output  8  write data.
REQ-012 spi_ack  input  1  one-cycle completion pulse from engine.
REQ-013 spi_rdata  input  8  read data, valid in the spi_ack cycle.
REQ-014 data_x, data_y  output  16 each  last complete sample, {high byte, low byte}.
REQ-015 data_update  output  1  one-cycle pulse when data_x/data_y change.
REQ-016 init_done  output  1  high once the init sequence has completed.
REQ-017 overrun  output  1  sticky: a sample tick arrived while a tick was already pending.
REQ-018 err_timeout  output  1  sticky: an ack timeout occurred.

Function
REQ-019 States SHALL be: INIT, IDLE, READ, COMMIT.
REQ-020 INIT SHALL issue writes in order: 6'h31<=FMT_VAL, 6'h2C<=RATE_VAL, 6'h2D<=8'h08; after the third ack it goes to IDLE and sets init_done.
REQ-021 READ SHALL issue reads in order: 6'h32 (X0), 6'h33 (X1), 6'h34 (Y0), 6'h35 (Y1), capturing spi_rdata into a shadow register on each ack.
REQ-022 Handshake: spi_req rises with spi_wr/spi_addr/spi_wdata valid, which stay stable until the ack cycle; spi_req is low in the cycle after ack; the next request rises no earlier than 1 cycle after that.
REQ-023 spi_ack while spi_req is low SHALL be ignored.
REQ-024 Tick counter SHALL count 0..TICK_DIV-1 and wrap continuously from reset, independent of state; each wrap sets pending.
REQ-025 IDLE -> READ when pending=1 and hold=0; pending clears on that transition.
REQ-026 Wrap with pending already set SHALL set overrun; pending stays 1 (no queueing beyond one).
REQ-027 Wrap in the same cycle pending clears SHALL leave pending=1 with no overrun.
REQ-028 COMMIT (1 cycle): data_x <= {X1,X0}, data_y <= {Y1,Y0}, data_update=1; then IDLE.
REQ-029 data_x/data_y SHALL change only in COMMIT; a partial read never reaches the outputs.
REQ-030 hold rising during READ SHALL NOT abort it; the current sample completes.
REQ-031 Timeout counter SHALL restart on each spi_req rise; reaching TIMEOUT cycles with no ack drops spi_req, sets err_timeout, clears init_done and returns to INIT from its first write.
REQ-032 Outputs SHALL be registered; latency from the 4th read ack to data_update is 1 cycle.

Reset
REQ-033 reset SHALL return state to INIT (first write) and tick counter, pending, shadow registers, data_x, data_y to 0, with spi_req, data_update, init_done, overrun and err_timeout low; the INIT sequence starts 1 cycle after reset deasserts.
REQ-034 reset mid-transaction SHALL drop spi_req in the next cycle; an ack arriving during or after reset is ignored.

Verification (TICK_DIV=16, TIMEOUT=8, engine acks 3 cycles after req)
REQ-035 Reset release -> writes (31,40), (2C,0A), (2D,08) in order; init_done=1 after the 3rd ack.
REQ-036 rdata 0x34,0x12,0xCD,0xAB -> data_x=16'h1234, data_y=16'hABCD, one data_update pulse, no output change before COMMIT.
REQ-037 hold=1 across 2 ticks -> no reads, overrun=1; hold=0 -> exactly one read burst.
REQ-038 Engine withholds ack on 2nd read -> spi_req drops 8 cycles after its rise, err_timeout=1, init_done=0, sequence restarts at 6'h31, data_x/data_y keep prior values.
REQ-039 reset asserted during 3rd read, ack arrives 1 cycle later -> ack ignored, outputs all 0, INIT restarts.
REQ-040 Stray spi_ack in IDLE -> no state change, no data_update.
